// File: rtl/cla_nibble_seq.sv
// Wide add/subtract controller that time-multiplexes one external 4-bit CLA slice,
// processing one nibble per clock (LSB first) with the carry held in a register.
module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       slice_x,
  output logic [3:0]       slice_y,
  output logic             slice_cin,
  input  logic [3:0]       slice_z,
  input  logic             slice_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_nib;

  assign last_nib = (idx_q == IW'(NIB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_nib) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    slice_x   = 4'd0;
    slice_y   = 4'd0;
    slice_cin = 1'b0;
    if (state_q == RUN) begin
      slice_x   = opa_q[4*idx_q +: 4];
      slice_y   = opb_q[4*idx_q +: 4];
      slice_cin = carry_q;
    end
  end

  // Operand, carry and result registers; opB is stored already inverted for subtract.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = slice_z;
        carry_d             = slice_cout;
        idx_d               = idx_q + IW'(1);
        if (last_nib) begin
          cout_d = slice_cout;
          ovf_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (slice_z[3] != opa_q[WIDTH-1]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq: behavioural CLA slice, arithmetic result model with a
// scoreboard queue, and directed vectors with hand-computed results.
module tb_cla_nibble_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;
  logic [3:0]   slice_x, slice_y, slice_z;
  logic         slice_cin, slice_cout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [17:0] expq[$];
  logic        cin_seen[0:7];
  int          lat;

  always #5 clk = ~clk;

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .slice_x(slice_x), .slice_y(slice_y), .slice_cin(slice_cin),
    .slice_z(slice_z), .slice_cout(slice_cout)
  );

  // The shared 4-bit slice is a plain combinational adder.
  assign {slice_cout, slice_z} = 5'(slice_x) + 5'(slice_y) + 5'(slice_cin);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result model: {ovf, cout, sum} from signed/unsigned integer arithmetic.
  function automatic logic [17:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mcin, input logic msub);
    int unsigned u;
    int          s;
    logic [W-1:0] bb;
    int          c;
    bb = msub ? ~mb : mb;
    c  = msub ? 1 : int'(mcin);
    u  = int'(ma) + int'(bb) + c;
    s  = int'($signed(ma)) + int'($signed(bb)) + c;
    return {(s > 32767 || s < -32768), u[16], u[15:0]};
  endfunction

  always @(posedge rst) expq.delete();

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
    end
  end

  // Every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("model_sum", 32'(sum), 32'(expq[0][15:0]));
        chk("model_cout", 32'(cout), 32'(expq[0][16]));
        chk("model_ovf", 32'(ovf), 32'(expq[0][17]));
        chk("in_ready_in_hold", 32'(in_ready), 32'd0);
      end
    end
  end

  // Present a bundle, wait for acceptance and for out_valid; leaves the result on the outputs.
  task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic tsub, input logic [W-1:0] esum, input logic ecout,
                       input logic eovf);
    int guard;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", 32'(guard < 20), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cin_seen[0] = slice_cin;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
      if (lat < 8) cin_seen[lat] = slice_cin;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("lit_sum", 32'(sum), 32'(esum));
    chk("lit_cout", 32'(cout), 32'(ecout));
    chk("lit_ovf", 32'(ovf), 32'(eovf));
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("retired", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    chk("rst_slice", 32'({slice_x, slice_y, slice_cin}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    start(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); retire();
    start(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("ripple_cin0", 32'(cin_seen[0]), 32'd0);
    chk("ripple_cin1", 32'(cin_seen[1]), 32'd1);
    chk("ripple_cin2", 32'(cin_seen[2]), 32'd1);
    chk("ripple_cin3", 32'(cin_seen[3]), 32'd1);
    retire();
    start(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); retire();
    start(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1); retire();
    start(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); retire();
    start(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0); retire();

    // Backpressure: result held, second bundle waits until IDLE.
    out_ready = 1'b0;
    start(16'hA5A5, 16'h1111, 1'b1, 1'b0, 16'hB6B7, 1'b0, 1'b0);
    held_sum = sum;
    a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum_stable", 32'(sum), 32'(held_sum));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    retire();
    start(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0); retire();

    // Reset in the middle of RUN.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_slice_x", 32'(slice_x), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_slice", 32'({slice_x, slice_y, slice_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'(out_valid), 32'd0);
    end
    start(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0); retire();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cla_nibble_seq.md
Name: cla_nibble_seq

Overview:
Multi-cycle wide adder/subtractor controller. It sequences one shared external 4-bit carry-lookahead adder slice, one nibble per cycle, LSB nibble first. The carry is held in a register between nibbles. Operands and results move over valid/ready handshakes, so one 4-bit CLA can serve WIDTH-bit adds in the arithmetic datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  1 = compute A-B (A + ~B + 1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow
slice_x  output  4  to shared CLA slice, x1..x4 = bits 0..3
slice_y  output  4  to shared CLA slice, y operand
slice_cin  output  1  to shared CLA slice, carry-in
slice_z  input  4  from shared CLA slice, sum nibble
slice_cout  input  1  from shared CLA slice, carry-out

Behaviour:
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, internal carry=0, nibble index=0, operand registers=0.
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a into opA. Capture b into opB, inverted when sub=1. Load carry register with (sub ? 1 : cin). Set idx=0. Go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Combinational drive: slice_x=opA[4*idx+3:4*idx], slice_y=opB nibble idx, slice_cin=carry register.
  - Each clock: write slice_z into sum nibble idx; carry register <= slice_cout; idx <= idx+1.
  - On the edge where idx=NIB-1: cout <= slice_cout; ovf <= (opA[W-1]==opB[W-1]) && (slice_z[3]!=opA[W-1]), where opB is the post-inversion value; out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready: out_valid <= 0, go to IDLE. in_ready returns to 1 in the next cycle. There is no same-cycle accept-and-retire.
- Latency: accept edge to out_valid high is exactly NIB clocks (4 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles with out_ready tied high.
- Slice outputs outside RUN: slice_x=0, slice_y=0, slice_cin=0.
- sum bits not yet written during RUN keep their previous values. Consumers may sample sum only while out_valid=1.
- WIDTH=4: RUN lasts one cycle.
- Reset asserted in any state: immediate return to reset values. An in-flight operation is discarded and no out_valid is produced.
- in_valid held through HOLD: not accepted until IDLE. The operand bundle must stay stable until accepted.
- Slice is purely combinational; the controller adds no pipeline stage to the slice path.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Carry ripples through the register on every nibble; probe slice_cin=1 in nibbles 1-3.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1. a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in HOLD -> sum/cout/ovf unchanged, in_ready=0, a second in_valid bundle is not accepted. After out_ready=1 for one cycle -> IDLE, then the second bundle is accepted.
- Assert rst during RUN at idx=2 -> all outputs at reset values in the same cycle; no out_valid follows. A new op after reset release produces a correct result (0x00FF+0x0001 -> 0x0100).
